// File: rtl/shift_arbiter.sv
// Arbitrates the ALU (requester 0) and the multi-cycle unit (requester 1) onto one external
// barrel shifter. Optional per-requester perf counters: define SHIFT_ARB_PERF_EN.
module shift_arbiter #(
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [1:0]  req_op0,
   input  logic [1:0]  req_op1,
   input  logic [31:0] req_data0,
   input  logic [31:0] req_data1,
   input  logic [4:0]  req_amt0,
   input  logic [4:0]  req_amt1,
   output logic [1:0]  rsp_valid,
   input  logic [1:0]  rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic [31:0] sh_m,
   output logic [4:0]  sh_n,
   output logic        sh_is_lsl,
   output logic        sh_is_lsr,
   output logic        sh_is_asr,
   input  logic [31:0] sh_result
`ifdef SHIFT_ARB_PERF_EN
  ,output logic [31:0] perf_grant0,
   output logic [31:0] perf_grant1,
   output logic [31:0] perf_stall
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic        r_last_grant;
   logic        r_owner;
   logic        r_err;
   logic [31:0] r_sh_m;
   logic [4:0]  r_sh_n;
   logic        r_lsl;
   logic        r_lsr;
   logic        r_asr;
   logic [31:0] r_rsp_data;
   logic        r_rsp_err;

   logic        w_grant;
   logic        w_accept;
   logic        w_rsp_done;
   logic [1:0]  w_sel_op;
   logic [31:0] w_sel_data;
   logic [4:0]  w_sel_amt;

   // Ties alternate against last_grant unless fixed priority pins them to requester 0.
   always_comb begin
      w_grant = 1'b0;
      if (req_valid == 2'b10)
         w_grant = 1'b1;
      else if (req_valid == 2'b11)
         w_grant = FIXED_PRIO ? 1'b0 : ~r_last_grant;
   end

   assign req_ready  = (r_state == S_IDLE && !reset && req_valid != 2'b00) ?
                       (w_grant ? 2'b10 : 2'b01) : 2'b00;
   assign w_accept   = |(req_valid & req_ready);
   assign w_sel_op   = w_grant ? req_op1   : req_op0;
   assign w_sel_data = w_grant ? req_data1 : req_data0;
   assign w_sel_amt  = w_grant ? req_amt1  : req_amt0;
   assign w_rsp_done = (r_state == S_RESP) && rsp_ready[r_owner];

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next_state = S_EXEC;
         S_EXEC:  w_next_state = S_RESP;
         S_RESP:  if (w_rsp_done) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so all registers see pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_last_grant <= 1'b1;
         r_owner      <= 1'b0;
         r_err        <= 1'b0;
         r_sh_m       <= '0;
         r_sh_n       <= '0;
         r_lsl        <= 1'b0;
         r_lsr        <= 1'b0;
         r_asr        <= 1'b0;
         r_rsp_data   <= '0;
         r_rsp_err    <= 1'b0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_sh_m       <= w_sel_data;
                  r_sh_n       <= w_sel_amt;
                  r_lsl        <= (w_sel_op == 2'b00);
                  r_lsr        <= (w_sel_op == 2'b01);
                  r_asr        <= (w_sel_op == 2'b11);
                  r_err        <= (w_sel_op == 2'b10);
                  r_owner      <= w_grant;
                  r_last_grant <= w_grant;
               end
            end
            S_EXEC: begin
               r_rsp_data <= r_err ? 32'd0 : sh_result;
               r_rsp_err  <= r_err;
            end
            S_RESP: begin
               // Shifter inputs go quiet while idle; the response payload stays put.
               if (w_rsp_done) begin
                  r_sh_m <= '0;
                  r_sh_n <= '0;
                  r_lsl  <= 1'b0;
                  r_lsr  <= 1'b0;
                  r_asr  <= 1'b0;
                  r_err  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign rsp_valid = (r_state == S_RESP) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_data  = r_rsp_data;
   assign rsp_err   = r_rsp_err;
   assign sh_m      = r_sh_m;
   assign sh_n      = r_sh_n;
   assign sh_is_lsl = r_lsl;
   assign sh_is_lsr = r_lsr;
   assign sh_is_asr = r_asr;

`ifdef SHIFT_ARB_PERF_EN
   logic [31:0] r_perf_grant0;
   logic [31:0] r_perf_grant1;
   logic [31:0] r_perf_stall;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_perf_grant0 <= '0;
         r_perf_grant1 <= '0;
         r_perf_stall  <= '0;
      end else begin
         if (w_accept && !w_grant) r_perf_grant0 <= r_perf_grant0 + 32'd1;
         if (w_accept && w_grant)  r_perf_grant1 <= r_perf_grant1 + 32'd1;
         if (req_valid != 2'b00 && req_ready == 2'b00) r_perf_stall <= r_perf_stall + 32'd1;
      end
   end

   assign perf_grant0 = r_perf_grant0;
   assign perf_grant1 = r_perf_grant1;
   assign perf_stall  = r_perf_stall;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed table, fairness/priority runs, mid-op reset
// and a randomized run against a transaction-level reference model.
module tb_shift_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
   logic [1:0]  req_op0, req_op1;
   logic [31:0] req_data0, req_data1;
   logic [4:0]  req_amt0, req_amt1;
   logic [31:0] rsp_data, sh_m, sh_result;
   logic        rsp_err;
   logic [4:0]  sh_n;
   logic        sh_is_lsl, sh_is_lsr, sh_is_asr;

   logic [1:0]  fp_req_valid, fp_req_ready, fp_rsp_valid, fp_rsp_ready;
   logic [31:0] fp_rsp_data, fp_sh_m, fp_sh_result;
   logic        fp_rsp_err;
   logic [4:0]  fp_sh_n;
   logic        fp_sh_is_lsl, fp_sh_is_lsr, fp_sh_is_asr;

`ifdef SHIFT_ARB_PERF_EN
   logic [31:0] perf_grant0, perf_grant1, perf_stall;
   logic [31:0] fp_perf_grant0, fp_perf_grant1, fp_perf_stall;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   // External barrel shifter stand-in.
   function automatic logic [31:0] shifter(input logic [31:0] m, input logic [4:0] n,
                                           input logic l, input logic r, input logic a);
      if (l)      return m << n;
      else if (r) return m >> n;
      else if (a) return 32'($signed(m) >>> n);
      else        return 32'd0;
   endfunction

   assign sh_result    = shifter(sh_m, sh_n, sh_is_lsl, sh_is_lsr, sh_is_asr);
   assign fp_sh_result = shifter(fp_sh_m, fp_sh_n, fp_sh_is_lsl, fp_sh_is_lsr, fp_sh_is_asr);

   shift_arbiter #(.FIXED_PRIO(1'b0)) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op0(req_op0), .req_op1(req_op1),
      .req_data0(req_data0), .req_data1(req_data1),
      .req_amt0(req_amt0), .req_amt1(req_amt1),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err),
      .sh_m(sh_m), .sh_n(sh_n),
      .sh_is_lsl(sh_is_lsl), .sh_is_lsr(sh_is_lsr), .sh_is_asr(sh_is_asr),
      .sh_result(sh_result)
`ifdef SHIFT_ARB_PERF_EN
     ,.perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_stall(perf_stall)
`endif
   );

   shift_arbiter #(.FIXED_PRIO(1'b1)) u_fp (
      .clk(clk), .reset(reset),
      .req_valid(fp_req_valid), .req_ready(fp_req_ready),
      .req_op0(req_op0), .req_op1(req_op1),
      .req_data0(req_data0), .req_data1(req_data1),
      .req_amt0(req_amt0), .req_amt1(req_amt1),
      .rsp_valid(fp_rsp_valid), .rsp_ready(fp_rsp_ready),
      .rsp_data(fp_rsp_data), .rsp_err(fp_rsp_err),
      .sh_m(fp_sh_m), .sh_n(fp_sh_n),
      .sh_is_lsl(fp_sh_is_lsl), .sh_is_lsr(fp_sh_is_lsr), .sh_is_asr(fp_sh_is_asr),
      .sh_result(fp_sh_result)
`ifdef SHIFT_ARB_PERF_EN
     ,.perf_grant0(fp_perf_grant0), .perf_grant1(fp_perf_grant1), .perf_stall(fp_perf_stall)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference result straight from the op definitions.
   function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] d,
                                              input logic [4:0] a);
      case (op)
         2'b00:   return d << a;
         2'b01:   return d >> a;
         2'b11:   return d[31] ? ~((~d) >> a) : (d >> a);
         default: return 32'd0;
      endcase
   endfunction

   // {lsl, lsr, asr}
   function automatic logic [2:0] ref_flags(input logic [1:0] op);
      case (op)
         2'b00:   return 3'b100;
         2'b01:   return 3'b010;
         2'b11:   return 3'b001;
         default: return 3'b000;
      endcase
   endfunction

   typedef struct {
      logic [1:0]  valid;
      logic [1:0]  op0;
      logic [31:0] d0;
      logic [4:0]  a0;
      logic [1:0]  op1;
      logic [31:0] d1;
      logic [4:0]  a1;
      int          owner;
      logic [31:0] exp_data;
      logic        exp_err;
      int          hold;
      int          linger;
   } vec_t;

   function automatic vec_t mk(input logic [1:0] valid,
                               input logic [1:0] op0, input logic [31:0] d0, input logic [4:0] a0,
                               input logic [1:0] op1, input logic [31:0] d1, input logic [4:0] a1,
                               input int owner, input logic [31:0] exp_data, input logic exp_err,
                               input int hold, input int linger);
      vec_t v;
      v.valid = valid; v.op0 = op0; v.d0 = d0; v.a0 = a0;
      v.op1 = op1; v.d1 = d1; v.a1 = a1;
      v.owner = owner; v.exp_data = exp_data; v.exp_err = exp_err;
      v.hold = hold; v.linger = linger;
      return v;
   endfunction

   task automatic run_vec(input vec_t v);
      logic [1:0]  own_op;
      logic [31:0] own_d;
      logic [4:0]  own_a;
      logic [1:0]  own_bit;
      own_op  = (v.owner == 1) ? v.op1 : v.op0;
      own_d   = (v.owner == 1) ? v.d1  : v.d0;
      own_a   = (v.owner == 1) ? v.a1  : v.a0;
      own_bit = (v.owner == 1) ? 2'b10 : 2'b01;
      @(negedge clk);
      req_valid = v.valid;
      req_op0 = v.op0; req_data0 = v.d0; req_amt0 = v.a0;
      req_op1 = v.op1; req_data1 = v.d1; req_amt1 = v.a1;
      rsp_ready = 2'b00;
      #1;
      check("vec_grant", 32'(req_ready), 32'(own_bit));
      @(negedge clk);
      if (v.linger < 1) req_valid = 2'b00;
      #1;
      check("exec_ready", 32'(req_ready), 32'd0);
      check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
      check("exec_sh_m", sh_m, own_d);
      check("exec_sh_n", 32'(sh_n), 32'(own_a));
      check("exec_flags", 32'({sh_is_lsl, sh_is_lsr, sh_is_asr}), 32'(ref_flags(own_op)));
      @(negedge clk);
      if (v.linger < 2) req_valid = 2'b00;
      #1;
      check("resp_valid", 32'(rsp_valid), 32'(own_bit));
      check("resp_data", rsp_data, v.exp_data);
      check("resp_err", 32'(rsp_err), 32'(v.exp_err));
      rsp_ready = ~own_bit;
      for (int h = 0; h < v.hold; h++) begin
         @(negedge clk);
         #1;
         check("hold_valid", 32'(rsp_valid), 32'(own_bit));
         check("hold_data", rsp_data, v.exp_data);
         check("hold_sh_m", sh_m, own_d);
         check("hold_flags", 32'({sh_is_lsl, sh_is_lsr, sh_is_asr}), 32'(ref_flags(own_op)));
      end
      rsp_ready = own_bit;
      @(negedge clk);
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      #1;
      check("done_rsp_valid", 32'(rsp_valid), 32'd0);
      check("done_sh_m", sh_m, 32'd0);
      check("done_flags", 32'({sh_is_lsl, sh_is_lsr, sh_is_asr}), 32'd0);
      check("done_data_held", rsp_data, v.exp_data);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      req_valid = 2'b00; rsp_ready = 2'b00;
      fp_req_valid = 2'b00; fp_rsp_ready = 2'b00;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   vec_t vecs[7];
   int   exp_g0, exp_g1, exp_stall;
   int   q_rr[$];
   int   q_fp[$];
   int   fp_r1_seen;

   // Randomized-run reference model state.
   bit          m_busy, m_in_resp, m_last;
   int          m_owner;
   logic [1:0]  m_op;
   logic [31:0] m_d, m_result, m_rsp_data;
   logic [4:0]  m_a;
   logic        m_rsp_err;

   initial begin
      reset = 1'b1;
      req_valid = 2'b11; rsp_ready = 2'b00;
      fp_req_valid = 2'b11; fp_rsp_ready = 2'b00;
      req_op0 = 2'b00; req_op1 = 2'b00;
      req_data0 = '0; req_data1 = '0; req_amt0 = '0; req_amt1 = '0;

      // Reset state, with requests pending to show ready stays low.
      repeat (2) @(negedge clk);
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_fp_req_ready", 32'(fp_req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_data", rsp_data, 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      check("rst_sh_m", sh_m, 32'd0);
      check("rst_sh_n", 32'(sh_n), 32'd0);
      check("rst_flags", 32'({sh_is_lsl, sh_is_lsr, sh_is_asr}), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      req_valid = 2'b00; fp_req_valid = 2'b00;

      vecs[0] = mk(2'b01, 2'b00, 32'h0000_0001, 5'd4,  2'b00, 32'h0, 5'd0,
                   0, 32'h0000_0010, 1'b0, 0, 1);
      vecs[1] = mk(2'b10, 2'b00, 32'h0, 5'd0, 2'b11, 32'h8000_0000, 5'd31,
                   1, 32'hFFFF_FFFF, 1'b0, 5, 0);
      vecs[2] = mk(2'b01, 2'b10, 32'h1234_5678, 5'd7, 2'b00, 32'h0, 5'd0,
                   0, 32'h0000_0000, 1'b1, 0, 2);
      vecs[3] = mk(2'b10, 2'b00, 32'h0, 5'd0, 2'b01, 32'h8000_0000, 5'd1,
                   1, 32'h4000_0000, 1'b0, 0, 0);
      vecs[4] = mk(2'b01, 2'b00, 32'hDEAD_BEEF, 5'd0, 2'b00, 32'h0, 5'd0,
                   0, 32'hDEAD_BEEF, 1'b0, 0, 0);
      vecs[5] = mk(2'b11, 2'b00, 32'h0000_AAAA, 5'd1, 2'b01, 32'h0000_00F0, 5'd4,
                   1, 32'h0000_000F, 1'b0, 0, 0);
      vecs[6] = mk(2'b11, 2'b00, 32'h0000_AAAA, 5'd1, 2'b01, 32'h0000_00F0, 5'd4,
                   0, 32'h0001_5554, 1'b0, 0, 0);

      exp_g0 = 0; exp_g1 = 0; exp_stall = 0;
      for (int i = 0; i < 7; i++) begin
         run_vec(vecs[i]);
         if (vecs[i].owner == 1) exp_g1++; else exp_g0++;
         exp_stall += vecs[i].linger;
      end

`ifdef SHIFT_ARB_PERF_EN
      check("perf_grant0", perf_grant0, 32'(exp_g0));
      check("perf_grant1", perf_grant1, 32'(exp_g1));
      check("perf_stall", perf_stall, 32'(exp_stall));
`endif

      // Reset while in EXEC: no response, outputs back to reset values.
      @(negedge clk);
      req_valid = 2'b01; req_op0 = 2'b00; req_data0 = 32'h5; req_amt0 = 5'd1;
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      check("pre_rst_exec_sh_m", sh_m, 32'h5);
      reset = 1'b1;
      @(negedge clk);
      #1;
      check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("midrst_req_ready", 32'(req_ready), 32'd0);
      check("midrst_sh_m", sh_m, 32'd0);
      check("midrst_flags", 32'({sh_is_lsl, sh_is_lsr, sh_is_asr}), 32'd0);
      check("midrst_rsp_data", rsp_data, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      req_valid = 2'b11;
      #1;
      check("midrst_rsp_valid2", 32'(rsp_valid), 32'd0);
      check("midrst_tie_req0", 32'(req_ready), 32'd1);
      req_valid = 2'b00;

      // Continuous contention: round-robin vs fixed priority.
      apply_reset();
      req_op0 = 2'b00; req_data0 = 32'h1; req_amt0 = 5'd1;
      req_op1 = 2'b01; req_data1 = 32'h8; req_amt1 = 5'd1;
      req_valid = 2'b11; fp_req_valid = 2'b11;
      rsp_ready = 2'b11; fp_rsp_ready = 2'b11;
      fp_r1_seen = 0;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (req_ready != 2'b00) q_rr.push_back(req_ready[1] ? 1 : 0);
         if (fp_req_ready != 2'b00) q_fp.push_back(fp_req_ready[1] ? 1 : 0);
         if (fp_req_ready[1]) fp_r1_seen++;
         @(negedge clk);
      end
      req_valid = 2'b00; fp_req_valid = 2'b00;
      check("rr_grant_count", 32'(q_rr.size()), 32'd4);
      check("fp_grant_count", 32'(q_fp.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check("rr_order", 32'((i < q_rr.size()) ? q_rr[i] : 99), 32'(i % 2));
         check("fp_order", 32'((i < q_fp.size()) ? q_fp[i] : 99), 32'd0);
      end
      check("fp_req1_never", 32'(fp_r1_seen), 32'd0);

      // Randomized traffic against the transaction model.
      apply_reset();
      m_busy = 1'b0; m_in_resp = 1'b0; m_last = 1'b1; m_owner = 0;
      m_op = '0; m_d = '0; m_a = '0; m_result = '0;
      m_rsp_data = '0; m_rsp_err = 1'b0;
      for (int c = 0; c < 400; c++) begin
         logic [1:0] e_ready, e_rvalid;
         logic [2:0] e_flags;
         logic [31:0] e_m;
         logic [4:0] e_n;
         int g;
         @(negedge clk);
         req_valid = 2'($urandom_range(0, 3));
         req_op0 = 2'($urandom_range(0, 3)); req_data0 = $urandom; req_amt0 = 5'($urandom_range(0, 31));
         req_op1 = 2'($urandom_range(0, 3)); req_data1 = $urandom; req_amt1 = 5'($urandom_range(0, 31));
         rsp_ready = 2'($urandom_range(0, 3));
         #1;
         g = 0;
         if (req_valid == 2'b10) g = 1;
         else if (req_valid == 2'b11) g = m_last ? 0 : 1;
         e_ready = 2'b00; e_rvalid = 2'b00; e_flags = 3'b000; e_m = '0; e_n = '0;
         if (!m_busy) begin
            if (req_valid != 2'b00) e_ready = (g == 1) ? 2'b10 : 2'b01;
         end else begin
            e_flags = ref_flags(m_op); e_m = m_d; e_n = m_a;
            if (m_in_resp) e_rvalid = (m_owner == 1) ? 2'b10 : 2'b01;
         end
         check("rnd_req_ready", 32'(req_ready), 32'(e_ready));
         check("rnd_rsp_valid", 32'(rsp_valid), 32'(e_rvalid));
         check("rnd_rsp_data", rsp_data, m_rsp_data);
         check("rnd_rsp_err", 32'(rsp_err), 32'(m_rsp_err));
         check("rnd_sh_m", sh_m, e_m);
         check("rnd_sh_n", 32'(sh_n), 32'(e_n));
         check("rnd_flags", 32'({sh_is_lsl, sh_is_lsr, sh_is_asr}), 32'(e_flags));
         if (!m_busy) begin
            if (req_valid != 2'b00) begin
               m_busy = 1'b1; m_in_resp = 1'b0; m_owner = g; m_last = (g == 1);
               m_op = (g == 1) ? req_op1 : req_op0;
               m_d  = (g == 1) ? req_data1 : req_data0;
               m_a  = (g == 1) ? req_amt1 : req_amt0;
               m_result = ref_result(m_op, m_d, m_a);
            end
         end else if (!m_in_resp) begin
            m_in_resp = 1'b1;
            m_rsp_data = m_result;
            m_rsp_err = (m_op == 2'b10);
         end else if (rsp_ready[m_owner]) begin
            m_busy = 1'b0; m_in_resp = 1'b0;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares the single combinational barrel shifter (32-bit LSL/LSR/ASR, 5-bit amount) between two requesters.
- Requester 0: execute-stage ALU. Requester 1: multi-cycle unit (mul/div normalisation).
- Arbitrates, registers the winning operands onto the shifter inputs, captures the result and returns it to the winning requester over a valid/ready handshake.
- Sits beside the shifter in the execute stage; the shifter itself is instantiated outside this block.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin; 1 = requester 0 always wins ties.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- req_valid  input  2  per-requester request valid (bit i = requester i)
- req_ready  output  2  per-requester accept
- req_op0, req_op1  input  2 each  op: 00 LSL, 01 LSR, 11 ASR, 10 illegal
- req_data0, req_data1  input  32 each  operand
- req_amt0, req_amt1  input  5 each  shift amount
- rsp_valid  output  2  per-requester response valid
- rsp_ready  input  2  per-requester response accept
- rsp_data  output  32  result, shared by both requesters
- rsp_err  output  1  result came from an illegal op
- sh_m  output  32  to shifter operand input
- sh_n  output  5  to shifter amount input
- sh_is_lsl, sh_is_lsr, sh_is_asr  output  1 each  to shifter op selects (one-hot or all zero)
- sh_result  input  32  from shifter, combinational in sh_*

Behaviour:
- Reset values:
  - state IDLE; last_grant = 1, so requester 0 wins the first tie.
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0; all sh_* = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready = 2'b11 masked to the granted requester only. Combinational grant from req_valid and last_grant.
  - Grant rules:
    - Single valid request: grant it.
    - Both valid, FIXED_PRIO=0: grant !last_grant.
    - Both valid, FIXED_PRIO=1: grant requester 0.
  - On accept (req_valid[g] && req_ready[g]):
    - Register sh_m/sh_n and the op-select flags (illegal op: all flags 0, err_q=1). Register owner=g and last_grant=g.
    - Go to EXEC.
- EXEC (exactly 1 cycle):
  - req_ready=0; sh_* held stable.
  - Capture rsp_data<=sh_result (forced to 0 if err_q) and rsp_err<=err_q. Go to RESP.
- RESP:
  - rsp_valid[owner]=1, other bit 0; rsp_data, rsp_err and sh_* held stable.
  - When rsp_ready[owner]: rsp_valid drops next cycle, go to IDLE. rsp_ready of the non-owner is ignored.
- Latency:
  - Accept at cycle T; rsp_valid at T+2.
  - A new accept is possible in the cycle after the handshake completes, so the minimum issue interval is 3 cycles.
- A requester dropping req_valid without acceptance is legal; there is no grant memory beyond last_grant.
- Zero shift amount: passthrough of req_data as computed by the shifter; no special case.
- sh_* return to 0 on entering IDLE. rsp_data is held until the next EXEC capture.
- Reset mid-operation (EXEC or RESP): in-flight op discarded, no response issued; all outputs at reset values the next cycle.
- No starvation with FIXED_PRIO=0: under continuous requests from both, grants alternate 0,1,0,1.

Optional Feature:
- SHIFT_ARB_PERF_EN:
  - Defined: adds outputs perf_grant0 and perf_grant1 (32 each), counting accepts per requester, and perf_stall (32), counting cycles where req_valid is nonzero and req_ready is zero.
  - Counters wrap at 2^32 and are cleared by reset.
  - Undefined: these ports and counters do not exist; the remaining behaviour is identical.

Test Plan:
- Req0 only, LSL data=0x0000_0001 amt=4 -> sh_is_lsl=1 and sh_m=0x1 in EXEC; rsp_valid=2'b01 at T+2 with rsp_data=0x0000_0010, rsp_err=0.
- Req1 only, ASR data=0x8000_0000 amt=31 -> rsp_valid=2'b10 with rsp_data=0xFFFF_FFFF; hold rsp_ready=0 for 5 cycles -> rsp_data and sh_* stable throughout.
- Both valid continuously, FIXED_PRIO=0, after reset -> grant order 0,1,0,1; with FIXED_PRIO=1 -> 0,0,0,0 and requester 1 never accepted.
- Req0 op=10 data=0x1234_5678 -> all sh_is_* = 0 in EXEC; rsp_data=0, rsp_err=1.
- Assert reset in EXEC -> next cycle rsp_valid=0, req_ready=0, sh_*=0; the following request from requester 0 wins a tie.
- With SHIFT_ARB_PERF_EN, 3 grants to requester 0 and 2 to requester 1 -> perf_grant0=3, perf_grant1=2, and perf_stall equals the counted blocked cycles.
